// File: rtl/mem_1r1w_masked_pipe_if.sv
// mem_1r1w_masked_pipe_if: read and write port bundle for the masked 1R1W memory.
// Latency: none (wires only); the memory defines the read timing.
// Backpressure: none; the requester drives R0_*/W0_*, the memory returns R0_data/R0_valid.
interface mem_1r1w_masked_pipe_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int MASK_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] R0_addr;
  logic                  R0_en;
  logic [WIDTH-1:0]      R0_data;
  logic                  R0_valid;
  logic [ADDR_WIDTH-1:0] W0_addr;
  logic                  W0_en;
  logic [WIDTH-1:0]      W0_data;
  logic [MASK_WIDTH-1:0] W0_mask;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid
  );
endinterface

// File: rtl/mem_1r1w_masked_pipe.sv
// mem_1r1w_masked_pipe: parametrised lane-masked 1R1W memory, zeroed by a DEPTH-cycle sweep after reset.
// Latency: writes commit at the edge; read data/valid appear READ_LATENCY cycles after issue.
// Backpressure: none; user ports are ignored while init_busy=1. Optional MEM_1R1W_MASKED_PIPE_BYPASS_EN merges a same-address write into the read.
module mem_1r1w_masked_pipe #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 64,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int MASK_WIDTH   = WIDTH / MASK_GRAN
) (
  input  logic                    clock,
  input  logic                    reset,
  mem_1r1w_masked_pipe_if.slave   bus,
  output logic                    init_busy
);

  // Parameter legality is checked at elaboration so illegal builds never produce a netlist.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_1r1w_masked_pipe: DEPTH must be a power of two >= 2");
  end
  if (MASK_GRAN < 1 || (WIDTH % ((MASK_GRAN < 1) ? 1 : MASK_GRAN)) != 0) begin : g_bad_gran
    $error("mem_1r1w_masked_pipe: WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_lat
    $error("mem_1r1w_masked_pipe: READ_LATENCY must be 1..3");
  end
  if (ADDR_WIDTH != $clog2(DEPTH) || MASK_WIDTH * MASK_GRAN != WIDTH) begin : g_bad_derived
    $error("mem_1r1w_masked_pipe: ADDR_WIDTH/MASK_WIDTH are derived and must not be overridden");
  end

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH-1:0]      wr_bits;
  logic [WIDTH-1:0]      user_bits;

  logic                  rd_issue;
  logic [WIDTH-1:0]      rd_word;

  logic [WIDTH-1:0]        pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;

  // Init sweep FSM: walk cnt over every address once, then hand the array to the user ports.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
        end
        default: begin
          state     <= INIT;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Expand the per-lane write mask into a per-bit enable.
  always_comb begin
    user_bits = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      user_bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.W0_mask[i]}};
    end
  end

  // Write port source: the sweep owns the array in INIT, the user port in READY.
  always_comb begin
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = '0;
      wr_bits = '1;
    end else begin
      wr_en   = bus.W0_en;
      wr_addr = bus.W0_addr;
      wr_data = bus.W0_data;
      wr_bits = user_bits;
    end
  end

  // Array update; only the enabled lanes of the addressed word change.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
    end
  end

  assign rd_issue = (state == READY) && bus.R0_en;

`ifdef MEM_1R1W_MASKED_PIPE_BYPASS_EN
  // Read sample with same-cycle write forwarding on the written lanes.
  always_comb begin
    rd_word = mem[bus.R0_addr];
    if (state == READY && bus.W0_en && bus.W0_addr == bus.R0_addr) begin
      rd_word = (rd_word & ~user_bits) | (bus.W0_data & user_bits);
    end
  end
`else
  // Read sample sees the array before this edge's write, so collisions return old data.
  assign rd_word = mem[bus.R0_addr];
`endif

  // Read pipeline: data captured at issue, then shifted only alongside its valid so the output holds when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_issue;
      if (rd_issue) begin
        pipe_data[0] <= rd_word;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  assign bus.R0_data  = pipe_data[READ_LATENCY-1];
  assign bus.R0_valid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1r1w_masked_pipe.sv
// tb_mem_1r1w_masked_pipe: directed bench for the masked 1R1W memory at read latency 1 and 3.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_mem_1r1w_masked_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy1;
  logic busy3;
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  mem_1r1w_masked_pipe_if #(.ADDR_WIDTH(5), .WIDTH(64), .MASK_WIDTH(8)) bus1 ();
  mem_1r1w_masked_pipe_if #(.ADDR_WIDTH(5), .WIDTH(64), .MASK_WIDTH(8)) bus3 ();

  mem_1r1w_masked_pipe #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .init_busy(busy1)
  );

  mem_1r1w_masked_pipe #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3), .init_busy(busy3)
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_all();
    bus1.R0_en = 1'b0; bus1.R0_addr = '0; bus1.W0_en = 1'b0; bus1.W0_addr = '0;
    bus1.W0_data = '0; bus1.W0_mask = '0;
    bus3.R0_en = 1'b0; bus3.R0_addr = '0; bus3.W0_en = 1'b0; bus3.W0_addr = '0;
    bus3.W0_data = '0; bus3.W0_mask = '0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    step(); step();
    checks++; if (busy1 !== 1'b1) $display("FAIL reset_busy1: got %b want 1", busy1); else passed++;
    checks++; if (bus1.R0_valid !== 1'b0) $display("FAIL reset_valid1: got %b want 0", bus1.R0_valid); else passed++;
    checks++; if (bus1.R0_data !== 64'h0) $display("FAIL reset_data1: got %h want 0", bus1.R0_data); else passed++;
    checks++; if (busy3 !== 1'b1) $display("FAIL reset_busy3: got %b want 1", busy3); else passed++;
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL reset_valid3: got %b want 0", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'h0) $display("FAIL reset_data3: got %h want 0", bus3.R0_data); else passed++;
  endtask

  // User traffic during the sweep must neither write nor return reads.
  task automatic test_init_lockout();
    int n;
    int bad;
    bus1.W0_en = 1'b1; bus1.W0_addr = 5'd2; bus1.W0_data = 64'hDEAD; bus1.W0_mask = 8'hFF;
    bus1.R0_en = 1'b1; bus1.R0_addr = 5'd2;
    reset = 1'b0;
    n = 0;
    bad = 0;
    while (busy1 === 1'b1 && n < 100) begin
      if (bus1.R0_valid !== 1'b0) bad++;
      n++;
      step();
    end
    idle_all();
    checks++; if (n != 32) $display("FAIL init_busy_cycles: got %0d want 32", n); else passed++;
    checks++; if (bad != 0) $display("FAIL init_valid_lockout: got %0d valid cycles want 0", bad); else passed++;
    checks++; if (busy3 !== 1'b0) $display("FAIL init_busy3_done: got %b want 0", busy3); else passed++;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      bus1.R0_en = 1'b1;
      bus1.R0_addr = 5'(i);
      step();
      checks++; if (bus1.R0_valid !== 1'b1) $display("FAIL sweep_valid[%0d]: got %b want 1", i, bus1.R0_valid); else passed++;
      checks++; if (bus1.R0_data !== 64'h0) $display("FAIL sweep_data[%0d]: got %h want 0", i, bus1.R0_data); else passed++;
    end
    bus1.R0_en = 1'b0;
    step();
    checks++; if (bus1.R0_valid !== 1'b0) $display("FAIL sweep_valid_end: got %b want 0", bus1.R0_valid); else passed++;
  endtask

  task automatic test_masked_write();
    bus1.W0_en = 1'b1; bus1.W0_addr = 5'd5; bus1.W0_data = 64'hFFFF_FFFF_FFFF_FFFF; bus1.W0_mask = 8'hFF;
    step();
    bus1.W0_data = 64'h1122_3344_5566_7788; bus1.W0_mask = 8'h0F;
    step();
    bus1.W0_data = 64'h0; bus1.W0_mask = 8'h00;
    step();
    bus1.W0_en = 1'b0; bus1.R0_en = 1'b1; bus1.R0_addr = 5'd5;
    step();
    bus1.R0_en = 1'b0;
    checks++; if (bus1.R0_valid !== 1'b1) $display("FAIL masked_valid: got %b want 1", bus1.R0_valid); else passed++;
    checks++; if (bus1.R0_data !== 64'hFFFF_FFFF_5566_7788) $display("FAIL masked_data: got %h want ffffffff55667788", bus1.R0_data); else passed++;
    step();
    checks++; if (bus1.R0_valid !== 1'b0) $display("FAIL masked_valid_idle: got %b want 0", bus1.R0_valid); else passed++;
    checks++; if (bus1.R0_data !== 64'hFFFF_FFFF_5566_7788) $display("FAIL masked_data_hold: got %h want ffffffff55667788", bus1.R0_data); else passed++;
  endtask

  task automatic test_collision();
    logic [63:0] exp_same;
`ifdef MEM_1R1W_MASKED_PIPE_BYPASS_EN
    exp_same = 64'hAAAA_AAAA_AAAA_5555;
`else
    exp_same = 64'hAAAA_AAAA_AAAA_AAAA;
`endif
    bus1.W0_en = 1'b1; bus1.W0_addr = 5'd9; bus1.W0_data = 64'hAAAA_AAAA_AAAA_AAAA; bus1.W0_mask = 8'hFF;
    step();
    bus1.W0_data = 64'h5555_5555_5555_5555; bus1.W0_mask = 8'h03;
    bus1.R0_en = 1'b1; bus1.R0_addr = 5'd9;
    step();
    bus1.W0_en = 1'b0;
    checks++; if (bus1.R0_data !== exp_same) $display("FAIL collide_same_cycle: got %h want %h", bus1.R0_data, exp_same); else passed++;
    step();
    checks++; if (bus1.R0_data !== 64'hAAAA_AAAA_AAAA_5555) $display("FAIL collide_next_read: got %h want aaaaaaaaaaaa5555", bus1.R0_data); else passed++;
    bus1.W0_en = 1'b1; bus1.W0_addr = 5'd10; bus1.W0_data = 64'h0123_4567_89AB_CDEF; bus1.W0_mask = 8'hFF;
    step();
    bus1.W0_en = 1'b0; bus1.R0_addr = 5'd10;
    checks++; if (bus1.R0_data !== 64'hAAAA_AAAA_AAAA_5555) $display("FAIL diff_addr_read: got %h want aaaaaaaaaaaa5555", bus1.R0_data); else passed++;
    step();
    bus1.R0_en = 1'b0;
    checks++; if (bus1.R0_data !== 64'h0123_4567_89AB_CDEF) $display("FAIL diff_addr_write: got %h want 0123456789abcdef", bus1.R0_data); else passed++;
    step();
  endtask

  task automatic test_latency3();
    bus3.W0_en = 1'b1; bus3.W0_addr = 5'd4; bus3.W0_data = 64'h0101_0101_0101_0101; bus3.W0_mask = 8'hFF;
    step();
    bus3.W0_addr = 5'd6; bus3.W0_data = 64'h0606_0606_0606_0606;
    step();
    bus3.W0_en = 1'b0; bus3.R0_en = 1'b1; bus3.R0_addr = 5'd4;
    step();
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL lat3_c0_valid: got %b want 0", bus3.R0_valid); else passed++;
    bus3.R0_addr = 5'd6;
    bus3.W0_en = 1'b1; bus3.W0_addr = 5'd4; bus3.W0_data = 64'hFFFF_FFFF_FFFF_FFFF; bus3.W0_mask = 8'hFF;
    step();
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL lat3_c1_valid: got %b want 0", bus3.R0_valid); else passed++;
    bus3.R0_en = 1'b0; bus3.W0_en = 1'b0;
    step();
    checks++; if (bus3.R0_valid !== 1'b1) $display("FAIL lat3_c3_valid: got %b want 1", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'h0101_0101_0101_0101) $display("FAIL lat3_c3_data: got %h want 0101010101010101", bus3.R0_data); else passed++;
    bus3.R0_en = 1'b1; bus3.R0_addr = 5'd4;
    step();
    checks++; if (bus3.R0_valid !== 1'b1) $display("FAIL lat3_c4_valid: got %b want 1", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'h0606_0606_0606_0606) $display("FAIL lat3_c4_data: got %h want 0606060606060606", bus3.R0_data); else passed++;
    bus3.R0_en = 1'b0;
    step();
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL lat3_c5_valid: got %b want 0", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'h0606_0606_0606_0606) $display("FAIL lat3_c5_hold: got %h want 0606060606060606", bus3.R0_data); else passed++;
    step();
    checks++; if (bus3.R0_valid !== 1'b1) $display("FAIL lat3_c6_valid: got %b want 1", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL lat3_c6_data: got %h want ffffffffffffffff", bus3.R0_data); else passed++;
    step();
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL lat3_c7_valid: got %b want 0", bus3.R0_valid); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int n;
    int bad;
    bus1.W0_en = 1'b1; bus1.W0_addr = 5'd7; bus1.W0_data = 64'h1234; bus1.W0_mask = 8'hFF;
    bus3.W0_en = 1'b1; bus3.W0_addr = 5'd7; bus3.W0_data = 64'h1234; bus3.W0_mask = 8'hFF;
    step();
    bus1.W0_en = 1'b0; bus1.R0_en = 1'b1; bus1.R0_addr = 5'd7;
    bus3.W0_en = 1'b0; bus3.R0_en = 1'b1; bus3.R0_addr = 5'd7;
    step();
    idle_all();
    reset = 1'b1;
    #1;
    checks++; if (bus1.R0_valid !== 1'b0) $display("FAIL midrst_valid1: got %b want 0", bus1.R0_valid); else passed++;
    checks++; if (bus1.R0_data !== 64'h0) $display("FAIL midrst_data1: got %h want 0", bus1.R0_data); else passed++;
    checks++; if (busy1 !== 1'b1) $display("FAIL midrst_busy1: got %b want 1", busy1); else passed++;
    checks++; if (bus3.R0_valid !== 1'b0) $display("FAIL midrst_valid3: got %b want 0", bus3.R0_valid); else passed++;
    step(); step();
    reset = 1'b0;
    n = 0;
    bad = 0;
    while (busy1 === 1'b1 && n < 100) begin
      if (bus1.R0_valid !== 1'b0 || bus3.R0_valid !== 1'b0) bad++;
      n++;
      step();
    end
    checks++; if (n != 32) $display("FAIL midrst_busy_cycles: got %0d want 32", n); else passed++;
    checks++; if (bad != 0) $display("FAIL midrst_stale_valid: got %0d valid cycles want 0", bad); else passed++;
    bus1.R0_en = 1'b1; bus1.R0_addr = 5'd7;
    bus3.R0_en = 1'b1; bus3.R0_addr = 5'd7;
    step();
    idle_all();
    checks++; if (bus1.R0_valid !== 1'b1) $display("FAIL midrst_read_valid1: got %b want 1", bus1.R0_valid); else passed++;
    checks++; if (bus1.R0_data !== 64'h0) $display("FAIL midrst_read_data1: got %h want 0", bus1.R0_data); else passed++;
    step(); step();
    checks++; if (bus3.R0_valid !== 1'b1) $display("FAIL midrst_read_valid3: got %b want 1", bus3.R0_valid); else passed++;
    checks++; if (bus3.R0_data !== 64'h0) $display("FAIL midrst_read_data3: got %h want 0", bus3.R0_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_init_lockout();
    test_sweep();
    test_masked_write();
    test_collision();
    test_latency3();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
